// File: rtl/rate_ctrl_if.sv
// rtl/rate_ctrl_if.sv - button pulse and LED display signal bundle for rate_ctrl
interface rate_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_pause;
    logic       btn_sweep;
    logic       clr;
    logic [3:0] count;
    logic [2:0] rate;
    logic [1:0] mode;
    logic       tick;

    modport master (
        output btn_up, btn_down, btn_pause, btn_sweep, clr,
        input  count, rate, mode, tick
    );

    modport slave (
        input  btn_up, btn_down, btn_pause, btn_sweep, clr,
        output count, rate, mode, tick
    );
endinterface

// File: rtl/rate_ctrl.sv
// rtl/rate_ctrl.sv - run/pause/sweep controller for the LED rate divider and display counter
module rate_ctrl #(
    parameter int unsigned CLK_HZ      = 125000000,
    parameter int unsigned SWEEP_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    rate_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_SWEEP = 2'b10
    } state_t;

    localparam logic [2:0]  RATE_MAX   = 3'd6;
    localparam logic [31:0] SWEEP_LAST = 32'(SWEEP_TICKS - 1);

    state_t      state_q, state_d;
    logic        ret_q, ret_d;          // 1: leaving PAUSE returns to SWEEP
    logic [2:0]  rate_q, rate_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] div_q, div_d;
    logic [31:0] sweep_q, sweep_d;
    logic        tick_q, tick_d;
    logic [31:0] last_div;
    logic        restart;

    // Terminal divider value for the current rate; all divides fold to constants
    always_comb begin
        case (rate_q)
            3'd0:    last_div = 32'(CLK_HZ / 1)  - 32'd1;
            3'd1:    last_div = 32'(CLK_HZ / 2)  - 32'd1;
            3'd2:    last_div = 32'(CLK_HZ / 3)  - 32'd1;
            3'd3:    last_div = 32'(CLK_HZ / 4)  - 32'd1;
            3'd4:    last_div = 32'(CLK_HZ / 5)  - 32'd1;
            3'd5:    last_div = 32'(CLK_HZ / 10) - 32'd1;
            default: last_div = 32'(CLK_HZ / 20) - 32'd1;
        endcase
    end

    // Next-state: mode transitions, rate selection, divider, counter and sweep stepping
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        rate_d  = rate_q;
        count_d = count_q;
        div_d   = div_q;
        sweep_d = sweep_q;
        tick_d  = 1'b0;
        restart = 1'b0;

        if (bus.clr) begin
            // clr outranks every button; pulses in the same cycle are dropped
            count_d = 4'd0;
            div_d   = 32'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.btn_pause) begin
                        state_d = ST_PAUSE;
                        ret_d   = 1'b0;
                    end else if (bus.btn_sweep) begin
                        state_d = ST_SWEEP;
                        sweep_d = 32'd0;
                    end else if (bus.btn_up && !bus.btn_down && rate_q != RATE_MAX) begin
                        rate_d  = rate_q + 3'd1;
                        restart = 1'b1;
                    end else if (bus.btn_down && !bus.btn_up && rate_q != 3'd0) begin
                        rate_d  = rate_q - 3'd1;
                        restart = 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (bus.btn_pause) begin
                        state_d = ST_PAUSE;
                        ret_d   = 1'b1;
                    end else if (bus.btn_sweep) begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.btn_pause) begin
                        state_d = ret_q ? ST_SWEEP : ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase

            // Divider only runs outside PAUSE; a real rate change restarts it without a tick
            if (state_q != ST_PAUSE) begin
                if (restart) begin
                    div_d = 32'd0;
                end else if (div_q == last_div) begin
                    div_d   = 32'd0;
                    count_d = count_q + 4'd1;
                    tick_d  = 1'b1;
                    if (state_q == ST_SWEEP) begin
                        if (sweep_q == SWEEP_LAST) begin
                            sweep_d = 32'd0;
                            rate_d  = (rate_q == RATE_MAX) ? 3'd0 : rate_q + 3'd1;
                        end else begin
                            sweep_d = sweep_q + 32'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 32'd1;
                end
            end
        end
    end

    // State register; every output comes straight from here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ret_q   <= 1'b0;
            rate_q  <= 3'd0;
            count_q <= 4'd0;
            div_q   <= 32'd0;
            sweep_q <= 32'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rate_q  <= rate_d;
            count_q <= count_d;
            div_q   <= div_d;
            sweep_q <= sweep_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.count = count_q;
    assign bus.rate  = rate_q;
    assign bus.mode  = state_q;
    assign bus.tick  = tick_q;
endmodule

// File: doc/rate_ctrl.md
# rate_ctrl

Run/pause/sweep controller for the LED rate counter datapath: owns the terminal-count divider and the 4-bit display counter, and sequences them from debounced button pulses. Sits between the button conditioning logic and the board LEDs, replacing the free-wrapping rate register with a saturating, glitch-free rate selector. Every rate change restarts the divider cleanly, and an automatic sweep mode steps through all rates.

## Interface
- CLK_HZ, 125000000, clock frequency; divider periods derive from it (benches use 120)
- SWEEP_TICKS, 16, ticks spent at each rate in SWEEP mode (≥1)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  one-cycle pulse: rate index +1
- btn_down  in  1  one-cycle pulse: rate index −1
- btn_pause  in  1  one-cycle pulse: toggle pause
- btn_sweep  in  1  one-cycle pulse: toggle sweep mode
- clr  in  1  one-cycle pulse: zero counter and divider
- count  out  4  display counter (drives LED[3:0])
- rate  out  3  current rate index, 0..6
- mode  out  2  00 RUN, 01 PAUSE, 10 SWEEP
- tick  out  1  one-cycle pulse coincident with each count increment

## Operation
- Rate index r selects period P(r) = CLK_HZ / D(r), with D = {1,2,3,4,5,10,20} for r = 0..6. P(r) is constant lookup; no runtime divide.
- Divider div_cnt (32 bit) counts 0..P(r)−1. On a clock edge where div_cnt = P(r)−1 and mode ≠ PAUSE: div_cnt←0, count←count+1 (wraps 15→0), tick←1. Otherwise tick←0.
- FSM states RUN, PAUSE, SWEEP; reset state RUN. A 1-bit ret register records the state PAUSE returns to.
  - RUN: btn_pause → PAUSE (ret=RUN); btn_sweep → SWEEP.
  - SWEEP: btn_pause → PAUSE (ret=SWEEP); btn_sweep → RUN, keeping current rate.
  - PAUSE: btn_pause → ret state; btn_sweep, btn_up and btn_down are ignored.
- Rate change in RUN: btn_up saturates at 6 and btn_down saturates at 0. A press that actually changes r sets div_cnt←0 with no tick that edge. A saturated press is a no-op: no restart.
- Rate in SWEEP: btn_up and btn_down are ignored. sweep_cnt counts ticks. On the SWEEP_TICKS-th tick, sweep_cnt←0, r←(r=6 ? 0 : r+1), and div_cnt restarts on the following edge. The tick itself is still issued.
- Entering SWEEP clears sweep_cnt. Leaving PAUSE resumes div_cnt from its held value.
- clr: count←0 and div_cnt←0, with no tick that edge. State, rate, ret and sweep_cnt are unchanged.
- Same-cycle priority: rst > clr > btn_pause > btn_sweep > btn_up/btn_down. Lower-priority pulses in that cycle are dropped. btn_up with btn_down is a no-op.

## Timing
- Reset values: count=0, rate=0, mode=00, tick=0, div_cnt=0, sweep_cnt=0, ret=RUN.
- rst asserted mid-count or in any mode restores all reset values on that edge.
- Tick cadence with constant rate and no pulses: the first tick is on the P(r)-th rising edge after reset release, then every P(r) cycles. tick and the new count are visible after the same edge.
- Button pulse latency: mode, rate and div_cnt update on the edge that samples the pulse. A restarted divider produces its next tick P(new r) edges later.
- No combinational path from any input to any output. All outputs are registered.
- In PAUSE, tick stays 0 and count and div_cnt are held indefinitely.

## Test plan
- CLK_HZ=120, reset then idle 500 cycles → ticks at edges 120, 240, 360, 480; count=4; mode=00.
- btn_up ×7 spaced 10 cycles, starting from rate 0 → rate ends at 6 (saturates); period 6; each changing press restarts div_cnt; 7th press does not restart.
- btn_pause at div_cnt=50 (r=0), hold 300 cycles, then btn_pause → no ticks while paused; next tick 69 cycles after resume; mode returns 00.
- btn_sweep with SWEEP_TICKS=2 → rate sequence 0,1,…,6,0; each rate lasts exactly 2 ticks; btn_pause and btn_pause again return to SWEEP (mode=10).
- Same-cycle clr + btn_up + btn_pause at count=9 → count=0, div_cnt=0, mode unchanged, rate unchanged.
- rst pulsed in SWEEP at rate 4, count 7 → next cycle count=0, rate=0, mode=00, tick=0.
